// File: rtl/sudoku_pkg.sv
// Shared definitions for the 4x4 Sudoku datapath: board geometry, value
// encoding, reader FSM states and the board-read port types.
package sudoku_pkg;

  localparam int NUM_CELLS = 16;
  localparam int IDX_W     = 4;
  localparam int VAL_W     = 3;
  localparam int CNT_W     = 5;

  localparam logic [VAL_W-1:0] EMPTY_VAL = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CELLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    FINISH
  } reader_state_t;

  typedef logic [IDX_W-1:0] cell_idx_t;
  typedef logic [VAL_W-1:0] cell_val_t;
  typedef logic [CNT_W-1:0] cell_cnt_t;

  // Request issued towards the board storage; response arrives one cycle later.
  typedef struct packed {
    logic      rd_en;
    cell_idx_t rd_idx;
  } board_rd_req_t;

  typedef struct packed {
    cell_val_t user_val;
    cell_val_t real_val;
  } board_rd_rsp_t;

  // A cell is shown as wrong only when the player has filled it in.
  function automatic logic cell_is_wrong(input cell_val_t user_v, input cell_val_t real_v);
    return (user_v != EMPTY_VAL) && (user_v != real_v);
  endfunction

endpackage

// File: rtl/sudoku_board_reader.sv
// Walks all board cells in index order, streams each to the display driver
// over valid/ready and reports mismatch/empty counts plus a solved flag.
module sudoku_board_reader
  import sudoku_pkg::*;
(
  input  logic             clka,
  input  logic             restart,
  input  logic             start,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [VAL_W-1:0] user_val,
  input  logic [VAL_W-1:0] real_val,
  output logic             disp_valid,
  input  logic             disp_ready,
  output logic [IDX_W-1:0] disp_idx,
  output logic [VAL_W-1:0] disp_val,
  output logic             disp_err,
  output logic             busy,
  output logic             done,
  output logic             solved,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] empty_cnt
);

  reader_state_t state_reg, state_next;
  cell_idx_t     idx_reg, idx_next;
  board_rd_rsp_t cell_reg, cell_next;
  cell_cnt_t     mismatch_reg, mismatch_next;
  cell_cnt_t     empty_reg, empty_next;
  logic          solved_reg, solved_next;
  board_rd_req_t rd_req;

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      cell_reg     <= '0;
      mismatch_reg <= '0;
      empty_reg    <= '0;
      solved_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      cell_reg     <= cell_next;
      mismatch_reg <= mismatch_next;
      empty_reg    <= empty_next;
      solved_reg   <= solved_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    cell_next     = cell_reg;
    mismatch_next = mismatch_reg;
    empty_next    = empty_reg;
    solved_next   = solved_reg;
    rd_req        = '0;
    disp_valid    = 1'b0;
    done          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next      = '0;
          mismatch_next = '0;
          empty_next    = '0;
          solved_next   = 1'b0;
          state_next    = READ;
        end
      end

      READ: begin
        rd_req.rd_en  = 1'b1;
        rd_req.rd_idx = idx_reg;
        state_next    = CAPT;
      end

      // Empty cells also count as mismatches whenever the solution is nonzero.
      CAPT: begin
        cell_next.user_val = user_val;
        cell_next.real_val = real_val;
        if (user_val != real_val) begin
          mismatch_next = mismatch_reg + CNT_W'(1);
        end
        if (user_val == EMPTY_VAL) begin
          empty_next = empty_reg + CNT_W'(1);
        end
        state_next = SEND;
      end

      SEND: begin
        disp_valid = 1'b1;
        if (disp_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = READ;
          end
        end
      end

      FINISH: begin
        done        = 1'b1;
        solved_next = (mismatch_reg == '0);
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat fields come straight from registers so they stay stable under back-pressure.
  assign rd_en        = rd_req.rd_en;
  assign rd_idx       = rd_req.rd_idx;
  assign disp_idx     = idx_reg;
  assign disp_val     = cell_reg.user_val;
  assign disp_err     = cell_is_wrong(cell_reg.user_val, cell_reg.real_val);
  assign busy         = (state_reg != IDLE);
  assign solved       = solved_reg;
  assign mismatch_cnt = mismatch_reg;
  assign empty_cnt    = empty_reg;

endmodule
